// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_pkg
// Purpose  : Shared SoC types and constants for the CSR arbiter family.
// Revision : 1.0 - initial release
// ============================================================================
package soc_pkg;

    localparam int          CSR_ARB_MAX_M     = 8;
    localparam logic [31:0] CSR_ARB_ERR_RDATA = 32'hDEAD_C5C5;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/soc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : soc_rr_pick
// Purpose  : Combinational round-robin picker: first set request at or above
//            i_ptr, wrapping at NUM_M.
// Revision : 1.0 - initial release
// ============================================================================
module soc_rr_pick #(
    parameter int NUM_M = 3,
    localparam int PW   = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic             o_any,
    output logic [PW-1:0]    o_idx
);

    logic [PW:0]   w_sum  [NUM_M];
    logic [PW-1:0] w_cand [NUM_M];

    // w_cand[k] is the master k places after the pointer, modulo NUM_M.
    for (genvar k = 0; k < NUM_M; k++) begin : g_cand
        assign w_sum[k]  = {1'b0, i_ptr} + (PW+1)'(k);
        assign w_cand[k] = (w_sum[k] >= (PW+1)'(NUM_M))
                         ? PW'(w_sum[k] - (PW+1)'(NUM_M))
                         : w_sum[k][PW-1:0];
    end

    // Scanning downward lets the candidate closest to the pointer win.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_any = 1'b1;
                o_idx = w_cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_csr_arb.sv
`default_nettype none
// ============================================================================
// Module   : soc_csr_arb
// Purpose  : Round-robin arbiter sharing one CSR slave between NUM_M masters,
//            with a per-transaction watchdog and sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module soc_csr_arb
    import soc_pkg::*;
#(
    parameter int          NUM_M       = 3,
    parameter int          AW          = 16,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = CSR_ARB_ERR_RDATA
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic [NUM_M-1:0]           m_vld,
    input  logic [NUM_M-1:0][3:0]      m_we,
    input  logic [NUM_M-1:0][AW-1:0]   m_addr,
    input  logic [NUM_M-1:0][31:0]     m_wdat,
    output logic [NUM_M-1:0]           m_rdy,
    output logic [31:0]                m_rdat,
    output logic                       s_vld,
    output logic [3:0]                 s_we,
    output logic [AW-1:0]              s_addr,
    output logic [31:0]                s_wdat,
    input  logic                       s_rdy,
    input  logic [31:0]                s_rdat,
    output logic                       err_o,
    output logic [2:0]                 err_id_o,
    input  logic                       err_clr_i
);

    localparam int            GW     = $clog2(NUM_M);
    localparam int            c_EIDW = $clog2(CSR_ARB_MAX_M);
    localparam logic [GW-1:0] c_LAST = GW'(NUM_M - 1);
    localparam logic [15:0]   c_TMO  = 16'(TIMEOUT_CYC);

    arb_state_t          r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_rr_ptr;
    logic [15:0]         r_wd_cnt;
    logic                r_err;
    logic [c_EIDW-1:0]   r_err_id;

    logic                w_any;
    logic [GW-1:0]       w_pick;
    logic                w_busy;
    logic                w_abort;
    logic                w_done;
    logic                w_tmo;
    logic                w_is_wr;
    logic [GW-1:0]       w_next_ptr;

    soc_rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .i_req (m_vld),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // A master dropping its request mid-flight aborts silently, ahead of
    // both completion and timeout; completion beats a coincident timeout.
    assign w_busy     = (r_state == ARB_BUSY);
    assign w_abort    = w_busy && !m_vld[r_grant];
    assign w_done     = w_busy && !w_abort && s_rdy;
    assign w_tmo      = w_busy && !w_abort && !s_rdy && (r_wd_cnt == c_TMO);
    assign w_is_wr    = |m_we[r_grant];
    assign w_next_ptr = (r_grant == c_LAST) ? '0 : r_grant + GW'(1);

    always_comb begin
        s_vld  = w_busy;
        s_we   = w_busy ? m_we[r_grant]   : 4'h0;
        s_addr = w_busy ? m_addr[r_grant] : '0;
        s_wdat = w_busy ? m_wdat[r_grant] : 32'h0;
        m_rdy  = '0;
        if (w_done || w_tmo) begin
            m_rdy[r_grant] = 1'b1;
        end
        if (w_done) begin
            m_rdat = w_is_wr ? 32'h0 : s_rdat;
        end else if (w_tmo) begin
            m_rdat = ERR_RDATA;
        end else begin
            m_rdat = 32'h0;
        end
    end

    assign err_o    = r_err;
    assign err_id_o = r_err_id;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
            r_err_id <= '0;
        end else begin
            // A clear in the same cycle as a timeout is applied first, so the
            // new timeout is what remains recorded.
            if (w_tmo && (!r_err || err_clr_i)) begin
                r_err    <= 1'b1;
                r_err_id <= c_EIDW'(r_grant);
            end else if (err_clr_i) begin
                r_err    <= 1'b0;
                r_err_id <= '0;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        r_wd_cnt <= '0;
                        r_state  <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_abort || w_done || w_tmo) begin
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (!s_rdy && (r_wd_cnt != 16'hFFFF)) begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_csr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_csr_arb
// Purpose  : Scoreboard bench for soc_csr_arb with a queue-based reference
//            model of round-robin service order, latency and error flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_csr_arb;

    localparam int          NM   = 3;
    localparam int          AW   = 16;
    localparam int          TMO  = 4;
    localparam logic [31:0] ERRW = 32'hDEAD_C5C5;

    logic                   clk    = 1'b0;
    logic                   arst_n = 1'b1;
    logic [NM-1:0]          m_vld  = '0;
    logic [NM-1:0][3:0]     m_we   = '0;
    logic [NM-1:0][AW-1:0]  m_addr = '0;
    logic [NM-1:0][31:0]    m_wdat = '0;
    logic [NM-1:0]          m_rdy;
    logic [31:0]            m_rdat;
    logic                   s_vld;
    logic [3:0]             s_we;
    logic [AW-1:0]          s_addr;
    logic [31:0]            s_wdat;
    logic                   s_rdy  = 1'b0;
    logic [31:0]            s_rdat = '0;
    logic                   err_o;
    logic [2:0]             err_id_o;
    logic                   err_clr_i = 1'b0;

    always #5 clk = ~clk;

    soc_csr_arb #(
        .NUM_M       (NM),
        .AW          (AW),
        .TIMEOUT_CYC (TMO),
        .ERR_RDATA   (ERRW)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .m_vld     (m_vld),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdat    (m_wdat),
        .m_rdy     (m_rdy),
        .m_rdat    (m_rdat),
        .s_vld     (s_vld),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdat    (s_wdat),
        .s_rdy     (s_rdy),
        .s_rdat    (s_rdat),
        .err_o     (err_o),
        .err_id_o  (err_id_o),
        .err_clr_i (err_clr_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   wdat;
    } txn_t;

    typedef struct {
        int            m;
        logic [31:0]   rdat;
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   wdat;
        int            lat;
    } exp_t;

    txn_t        mq [NM][$];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          mptr  = 0;
    bit          merr  = 1'b0;
    int          mid   = 0;
    int          slave_wait = 0;
    bit          hang   = 1'b0;
    bit          fix_en = 1'b0;
    logic [31:0] fix_data = '0;
    logic [NM-1:0] done_mask = '0;
    int          busy_len = 0;
    int          sv_cnt   = 0;
    logic [AW-1:0] prev_addr;
    logic [3:0]    prev_we;
    logic [31:0]   prev_wdat;

    function automatic logic [31:0] slave_word(logic [AW-1:0] a);
        return fix_en ? fix_data : (({16'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Slave: answers after slave_wait extra cycles unless hung.
    always @(posedge clk) begin
        #2;
        if (s_vld === 1'b1) begin
            sv_cnt++;
            s_rdy = !hang && (sv_cnt > slave_wait);
        end else begin
            sv_cnt = 0;
            s_rdy  = 1'b0;
        end
        s_rdat = s_rdy ? slave_word(s_addr) : $urandom;
    end

    // Monitor: pops the scoreboard on every completion strobe.
    always @(negedge clk) begin
        exp_t e;
        if (!arst_n || s_vld !== 1'b1) begin
            busy_len = 0;
        end else begin
            busy_len++;
            if (busy_len > 1) begin
                check("s_addr_stable", 32'(s_addr), 32'(prev_addr));
                check("s_we_stable",   32'(s_we),   32'(prev_we));
                check("s_wdat_stable", s_wdat,      prev_wdat);
            end
            prev_addr = s_addr;
            prev_we   = s_we;
            prev_wdat = s_wdat;
        end
        if (m_rdy !== '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: got m_rdy=%b want none", m_rdy);
            end else begin
                e = sb.pop_front();
                check("rdy_master", 32'(m_rdy),  32'(1 << e.m));
                check("rdat",       m_rdat,      e.rdat);
                check("s_addr",     32'(s_addr), 32'(e.addr));
                check("s_we",       32'(s_we),   32'(e.we));
                check("s_wdat",     s_wdat,      e.wdat);
                check("latency",    busy_len,    e.lat);
            end
            done_mask = done_mask | m_rdy;
        end
    end

    // Reference: serve pending masters in round-robin order from mptr.
    task automatic model_round();
        int   cnt [NM];
        int   pos [NM];
        int   left;
        int   w;
        int   c;
        bit   tmo;
        txn_t t;
        exp_t e;
        left = 0;
        for (int i = 0; i < NM; i++) begin
            cnt[i] = mq[i].size();
            pos[i] = 0;
            left  += cnt[i];
        end
        tmo = hang || (slave_wait > TMO);
        while (left > 0) begin
            w = -1;
            for (int k = 0; k < NM; k++) begin
                c = (mptr + k) % NM;
                if (w < 0 && pos[c] < cnt[c]) w = c;
            end
            t = mq[w][pos[w]];
            pos[w]++;
            left--;
            e.m    = w;
            e.addr = t.addr;
            e.we   = t.we;
            e.wdat = t.wdat;
            e.lat  = tmo ? TMO + 1 : slave_wait + 1;
            e.rdat = tmo ? ERRW : ((t.we != 4'h0) ? 32'h0 : slave_word(t.addr));
            if (tmo && !merr) begin
                merr = 1'b1;
                mid  = w;
            end
            sb.push_back(e);
            mptr = (w + 1) % NM;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            if (mq[i].size() > 0) begin
                m_vld[i]  = 1'b1;
                m_addr[i] = mq[i][0].addr;
                m_we[i]   = mq[i][0].we;
                m_wdat[i] = mq[i][0].wdat;
            end else begin
                m_vld[i]  = 1'b0;
                m_addr[i] = AW'($urandom);
                m_we[i]   = 4'($urandom);
                m_wdat[i] = $urandom;
            end
        end
    endtask

    task automatic run_round(string name);
        int n;
        int lat;
        int cyc;
        n = 0;
        for (int i = 0; i < NM; i++) n += mq[i].size();
        lat = (hang || slave_wait > TMO) ? TMO + 1 : slave_wait + 1;
        model_round();
        cyc = 0;
        @(posedge clk); #1;
        forever begin
            for (int i = 0; i < NM; i++) begin
                if (done_mask[i]) void'(mq[i].pop_front());
            end
            done_mask = '0;
            drive();
            if (mq[0].size() + mq[1].size() + mq[2].size() == 0) break;
            if (cyc >= 2000) begin
                $display("FAIL %s_hang: got no drain want drained", name);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_cycles"}, cyc, n * (lat + 1));
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_err"}, 32'(err_o), 32'(merr));
        check({name, "_err_id"}, 32'(err_id_o), mid);
    endtask

    task automatic push(int m, logic [AW-1:0] a, logic [3:0] we, logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.we   = we;
        t.wdat = d;
        mq[m].push_back(t);
    endtask

    initial begin
        exp_t e;
        int   k;
        #2 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_vld",  32'(s_vld),    0);
        check("rst_s_we",   32'(s_we),     0);
        check("rst_s_addr", 32'(s_addr),   0);
        check("rst_s_wdat", s_wdat,        0);
        check("rst_m_rdy",  32'(m_rdy),    0);
        check("rst_m_rdat", m_rdat,        0);
        check("rst_err",    32'(err_o),    0);
        check("rst_err_id", 32'(err_id_o), 0);
        arst_n = 1'b1;

        // Single master read with a fixed slave word.
        fix_en   = 1'b1;
        fix_data = 32'h1234_5678;
        push(1, 16'h0010, 4'h0, 32'h0);
        run_round("single");
        fix_en = 1'b0;

        // Everyone requesting continuously.
        for (int i = 0; i < 4; i++) push(0, AW'($urandom), 4'h0, $urandom);
        for (int i = 0; i < 3; i++) push(1, AW'($urandom), 4'hF, $urandom);
        for (int i = 0; i < 3; i++) push(2, AW'($urandom), 4'h0, $urandom);
        run_round("fair");

        slave_wait = 3;
        push(2, 16'h0104, 4'b0101, 32'hCAFE_F00D);
        run_round("write");

        slave_wait = 0;
        hang       = 1'b1;
        push(0, 16'h0020, 4'h0, 32'h0);
        run_round("tmo0");
        push(1, 16'h0024, 4'h0, 32'h0);
        run_round("tmo1");
        hang = 1'b0;
        @(posedge clk); #1 err_clr_i = 1'b1;
        @(posedge clk); #1 err_clr_i = 1'b0;
        merr = 1'b0;
        mid  = 0;
        check("clr_err",    32'(err_o),    0);
        check("clr_err_id", 32'(err_id_o), 0);

        // Slave answers exactly on the watchdog limit.
        slave_wait = TMO;
        push(mptr, 16'h0030, 4'h0, 32'h0);
        run_round("race_rdy");

        // Clear coincident with a timeout: timeout lands in busy cycle TMO+1.
        hang        = 1'b1;
        m_vld[0]    = 1'b1;
        m_we[0]     = 4'h0;
        m_addr[0]   = 16'h0200;
        e.m = 0; e.rdat = ERRW; e.addr = 16'h0200; e.we = 4'h0;
        e.wdat = m_wdat[0]; e.lat = TMO + 1;
        sb.push_back(e);
        repeat (TMO + 1) @(posedge clk);
        #1 err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        m_vld[0]  = 1'b0;
        done_mask = '0;
        merr = 1'b1;
        mid  = 0;
        mptr = 1;
        check("race_clr_err",    32'(err_o),    1);
        check("race_clr_err_id", 32'(err_id_o), 0);
        check("race_clr_sb",     sb.size(),     0);

        // Master1 abandons its request in the second BUSY cycle.
        m_vld[1]  = 1'b1;
        m_we[1]   = 4'h0;
        m_addr[1] = 16'h0300;
        repeat (2) @(posedge clk);
        #1 m_vld[1] = 1'b0;
        @(negedge clk);
        check("abort_svld_hold", 32'(s_vld), 1);
        check("abort_no_rdy",    32'(m_rdy), 0);
        @(posedge clk); #1;
        check("abort_idle", 32'(s_vld), 0);
        hang = 1'b0;
        mptr = 2;
        push(0, AW'($urandom), 4'h0, $urandom);
        push(1, AW'($urandom), 4'h0, $urandom);
        push(2, AW'($urandom), 4'h3, $urandom);
        run_round("after_abort");

        // Asynchronous reset in the middle of a hung transaction.
        hang      = 1'b1;
        m_vld[0]  = 1'b1;
        m_we[0]   = 4'hF;
        m_addr[0] = 16'h0400;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_svld", 32'(s_vld), 1);
        arst_n = 1'b0;
        #1;
        check("arst_s_vld",  32'(s_vld),    0);
        check("arst_s_we",   32'(s_we),     0);
        check("arst_s_addr", 32'(s_addr),   0);
        check("arst_s_wdat", s_wdat,        0);
        check("arst_m_rdy",  32'(m_rdy),    0);
        check("arst_m_rdat", m_rdat,        0);
        check("arst_err",    32'(err_o),    0);
        check("arst_err_id", 32'(err_id_o), 0);
        m_vld = '0;
        hang  = 1'b0;
        merr  = 1'b0;
        mid   = 0;
        mptr  = 0;
        @(posedge clk); #1 arst_n = 1'b1;

        // Randomized rounds, including slave waits past the watchdog.
        for (int r = 0; r < 10; r++) begin
            slave_wait = $urandom_range(0, 5);
            for (int i = 0; i < NM; i++) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    push(i, AW'($urandom),
                         ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                         $urandom);
                end
            end
            if (mq[0].size() + mq[1].size() + mq[2].size() == 0)
                push(0, AW'($urandom), 4'h0, $urandom);
            run_round("rand");
            if (r == 5) begin
                @(posedge clk); #1 err_clr_i = 1'b1;
                @(posedge clk); #1 err_clr_i = 1'b0;
                merr = 1'b0;
                mid  = 0;
                check("rand_clr", 32'(err_o), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
